uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the team's UART link. Frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 2 stop bits. Oversamples the asynchronous `rx` line with the system clock and samples each bit at mid-period. Presents each received byte with a one-cycle `rx_done` strobe plus parity and framing error flags.

## Interface
- `clk_freq`, default 1000000: system clock frequency in Hz.
- `baudrate`, default 9600: line bit rate.
- `CLKS_PER_BIT` (localparam) = `clk_freq/baudrate`, integer division (104 at defaults). Must be in the range 4..255.
- `HALF_BIT` (localparam) = `CLKS_PER_BIT/2`, integer division (52 at defaults).
- `clk` input 1: system clock; rising edge.
- `rst` input 1: reset; asynchronous, active-low.
- `rx` input 1: serial line, asynchronous, idle high.
- `data_out` output 8: last received byte.
- `rx_done` output 1: one-cycle strobe; `data_out` and error flags are updated in this cycle.
- `parity_err` output 1: last frame's parity check failed.
- `frame_err` output 1: last frame had a low stop bit.
- `rx_busy` output 1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a two-flop synchronizer, reset to 1, to give `rx_s`. All decisions use `rx_s`.
- Bit counter `clk_count` is 8 bits wide. Bit index is 3 bits wide.
- State machine:
  - **IDLE**: `clk_count` = 0. If `rx_s` = 0, go to START.
  - **START**: increment `clk_count`. When `clk_count` = `HALF_BIT`-1, clear the counter. If `rx_s` = 0, go to DATA with bit index 0. If `rx_s` = 1, treat it as a glitch and go to IDLE with no strobe and no flag change.
  - **DATA**: increment `clk_count`. When `clk_count` = `CLKS_PER_BIT`-1, clear the counter and write `rx_s` into shift data bit [index]. At index 7 go to PARITY; otherwise increment the index.
  - **PARITY**: at full period, capture `par_bad` = `rx_s` XOR (^data). Go to STOP1.
  - **STOP1**: at full period, capture `stop_bad` = ~`rx_s`. Go to STOP2.
  - **STOP2**: at full period:
    - `data_out` <= data.
    - `parity_err` <= `par_bad`.
    - `frame_err` <= `stop_bad` OR ~`rx_s`.
    - `rx_done` <= 1.
    - Go to IDLE.
- The byte is delivered even when a flag is set. The consumer decides whether to discard it.
- `rx_done` is cleared in every cycle in which it is not being set.
- `data_out`, `parity_err` and `frame_err` hold their values until the next `rx_done`.
- If `rx_s` is low in IDLE immediately after STOP2, including a break condition, a new START begins.
- Reset values: `data_out` = 0, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0, `rx_busy` = 0, state = IDLE, synchronizer = 11.
- Reset asserted mid-frame: return to reset values immediately. No strobe is issued, and the partial byte is lost.

## Timing
- Let E0 be the clock edge at which IDLE sees `rx_s` = 0.
- Start bit is verified at E0+`HALF_BIT` (E0+52).
- Data bit k (k = 0..7) is sampled at E0+`HALF_BIT`+`CLKS_PER_BIT`·(k+1).
- Parity is sampled at +9 periods, STOP1 at +10 periods, STOP2 at +11 periods, i.e. E0+1196 at defaults.
- `rx_done` is high for exactly the one cycle following E0+1196.
- From the falling edge on `rx` to E0: 2–3 cycles (synchronizer).
- `rx_busy` rises the cycle after E0 and falls together with `rx_done` rising.
- Back-to-back frames: the next start edge may arrive immediately after the second stop bit ends. Half a bit of margin remains, so no frame is missed.
- Tolerates ±4% baud mismatch; in that range every sample lands within the bit cell.

## Test plan
- **Reset**: hold `rst` = 0 with `rx` toggling. Required: all outputs at reset values, `rx_busy` = 0, no `rx_done`.
- **Good frame**: drive 0xA5 at 104 clk/bit (parity 0, stops 1,1). Required: one `rx_done` pulse; `data_out` = 0xA5; `parity_err` = 0; `frame_err` = 0; pulse 1196 ±3 cycles after the `rx` falling edge.
- **Loopback**: connect `uart_tx.tx` to `rx` and send 0x00, 0xFF, 0x3C, 0x81 back to back. Required: the four bytes are received in order with no flags; `rx_done` count equals `tx_done` count.
- **Parity error**: send 0x01 with parity bit 0. Required: `data_out` = 0x01 and `parity_err` = 1. A following good frame 0x02 clears `parity_err` to 0.
- **Framing and glitch**:
  - Send 0x55 with STOP1 = 0. Required: `frame_err` = 1, `data_out` = 0x55.
  - Drive a separate 20-cycle low pulse on an idle line. Required: no `rx_done`, `rx_busy` returns to 0 within 55 cycles, flags unchanged.
- **Reset mid-frame**: assert `rst` during data bit 4 of 0xC3, then release it and send 0x5A. Required: no strobe for 0xC3; 0x5A is received with no flags.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8E2 UART receiver, mid-bit sampling, parity/framing error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int clk_freq = 1000000,
  parameter int baudrate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  // CLKS_PER_BIT must stay within 4..255 so the 8-bit counter can hold it.
  localparam int CLKS_PER_BIT = clk_freq / baudrate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [7:0] c_bit_last  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] c_half_last = 8'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic [7:0]  clk_count_q, clk_count_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bad_q, par_bad_d;
  logic        stop_bad_q, stop_bad_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_done_q, rx_done_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      clk_count_q  <= 8'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      data_out_q   <= 8'd0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], rx};
      clk_count_q  <= clk_count_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_done_q    <= rx_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_count_d  = clk_count_q + 8'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        clk_count_d = 8'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A line that has gone high again by mid start bit was only a glitch.
        if (clk_count_q == c_half_last) begin
          clk_count_d = 8'd0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (clk_count_q == c_bit_last) begin
          clk_count_d        = 8'd0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = PARITY;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (clk_count_q == c_bit_last) begin
          clk_count_d = 8'd0;
          par_bad_d   = rx_s ^ (^shift_q);
          state_d     = STOP1;
        end
      end
      STOP1: begin
        if (clk_count_q == c_bit_last) begin
          clk_count_d = 8'd0;
          stop_bad_d  = ~rx_s;
          state_d     = STOP2;
        end
      end
      STOP2: begin
        if (clk_count_q == c_bit_last) begin
          clk_count_d  = 8'd0;
          data_out_d   = shift_q;
          parity_err_d = par_bad_q;
          frame_err_d  = stop_bad_q | ~rx_s;
          rx_done_d    = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        clk_count_d = 8'd0;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed scoreboard bench for uart_rx at 104 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.clk_freq(1000000), .baudrate(9600)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    bit         chk_t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc       = 0;
  int   fall_cyc  = 0;
  int   done_cnt  = 0;
  int   sent_cnt  = 0;
  int   checks    = 0;
  int   errors    = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued frame.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      if (prev_done === 1'b1) check("rx_done_width", 32'd2, 32'd1);
      check("busy_low_at_done", {31'd0, rx_busy}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        if (e.chk_t)
          check("done_latency_1196pm3", {31'd0, ((cyc - fall_cyc) >= 1193 && (cyc - fall_cyc) <= 1199)}, 32'd1);
      end
    end
    prev_done = rx_done;
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                            input logic s2, input bit chk_t);
    exp_t x;
    x.d     = d;
    x.pe    = par ^ (^d);
    x.fe    = ~(s1 & s2);
    x.chk_t = chk_t;
    sb.push_back(x);
    sent_cnt++;
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(s1);
    send_bit(s2);
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] part;
    logic [7:0] lb [4];
    int         done_before;
    bit         saw_busy;

    // Reset held with the line toggling
    rst = 1'b0;
    repeat (20) @(negedge clk) rx = ~rx;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rx = 1'b1;
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame with latency check
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);

    // Back-to-back stream, each start immediately after the second stop bit
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C; lb[3] = 8'h81;
    for (int i = 0; i < 4; i++) send_frame(lb[i], ^lb[i], 1'b1, 1'b1, 1'b0);

    // Parity error, then a good frame clears the flag
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    check("parity_err_held", {31'd0, parity_err}, 32'd1);
    send_frame(8'h02, 1'b1, 1'b1, 1'b1, 1'b0);
    check("parity_err_cleared", {31'd0, parity_err}, 32'd0);

    // Low first stop bit
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // 20-cycle glitch on an idle line
    done_before = done_cnt;
    saw_busy    = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
      else if (saw_busy) break;
    end
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_returned", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_done", done_cnt, done_before);
    check("glitch_data_kept", {24'd0, data_out}, 32'h55);
    check("glitch_parity_kept", {31'd0, parity_err}, 32'd0);
    check("glitch_frame_kept", {31'd0, frame_err}, 32'd1);

    // Reset in the middle of data bit 4 of 0xC3
    part = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    rx = part[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", {31'd0, rx_done}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);

    // Drain with a bounded wait
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("done_count", done_cnt, sent_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
